// File: rtl/e203_itcm_arbt_ctrl.sv
// ITCM arbiter: shares one single-port SRAM between IFU fetches and LSU loads/stores.
// LSU has priority. After IFU loses STARVE_MAX contested grants in a row, IFU wins
// the next one. The SRAM enters light sleep after LS_IDLE idle cycles.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   cfg_ls_en          enables automatic light sleep
//   ifu_cmd_*          IFU read request (valid/ready, word address)
//   ifu_rsp_*          IFU read response (valid/ready, data)
//   lsu_cmd_*          LSU request (valid/ready, read flag, address, write data, byte mask)
//   lsu_rsp_*          LSU response (valid/ready; data is 0 for writes)
//   ram_*              SRAM pins: cs/we/addr/wem/din out, dout in (1-cycle latency), ls out
module e203_itcm_arbt_ctrl #(
  parameter int unsigned AW         = 13,
  parameter int unsigned DW         = 64,
  parameter int unsigned MW         = 8,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned LS_IDLE    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_ls_en,
  input  logic          ifu_cmd_valid,
  output logic          ifu_cmd_ready,
  input  logic [AW-1:0] ifu_cmd_addr,
  output logic          ifu_rsp_valid,
  input  logic          ifu_rsp_ready,
  output logic [DW-1:0] ifu_rsp_rdata,
  input  logic          lsu_cmd_valid,
  output logic          lsu_cmd_ready,
  input  logic          lsu_cmd_read,
  input  logic [AW-1:0] lsu_cmd_addr,
  input  logic [DW-1:0] lsu_cmd_wdata,
  input  logic [MW-1:0] lsu_cmd_wmask,
  output logic          lsu_rsp_valid,
  input  logic          lsu_rsp_ready,
  output logic [DW-1:0] lsu_rsp_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_ls
);

  localparam int unsigned IW = $clog2(LS_IDLE + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {StIdle, StRsp, StSleep} state_e;

  state_e        state_q, state_d;
  logic          owner_lsu_q, owner_lsu_d;  // 1: response belongs to LSU
  logic          wr_q, wr_d;                // 1: response is for an LSU write
  logic          first_q, first_d;          // first response cycle, data comes from ram_dout
  logic [DW-1:0] hold_q, hold_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [IW-1:0] idle_q, idle_d;

  logic          any_valid;
  logic          owner_rsp_ready;
  logic          accept;
  logic          starved;
  logic          grant_ifu;
  logic          grant_lsu;
  logic          fire;
  logic          in_rsp;
  logic [DW-1:0] rsp_data;

  always_comb begin
    any_valid       = ifu_cmd_valid | lsu_cmd_valid;
    ram_ls          = (state_q == StSleep);
    in_rsp          = (state_q == StRsp);
    owner_rsp_ready = owner_lsu_q ? lsu_rsp_ready : ifu_rsp_ready;
    // Reset gates accept so no ready leaks out while rst is held.
    accept          = ~rst & ~ram_ls &
                      ((state_q == StIdle) | (in_rsp & owner_rsp_ready));
    starved         = (starve_q == SW'(STARVE_MAX));
    grant_ifu       = ifu_cmd_valid & (~lsu_cmd_valid | starved);
    grant_lsu       = lsu_cmd_valid & ~grant_ifu;
    fire            = accept & any_valid;

    ifu_cmd_ready   = accept & grant_ifu;
    lsu_cmd_ready   = accept & grant_lsu;

    ram_cs          = fire;
    ram_we          = fire & grant_lsu & ~lsu_cmd_read;
    ram_wem         = ram_we ? lsu_cmd_wmask : '0;
    ram_addr        = '0;
    if (fire) begin
      ram_addr = grant_ifu ? ifu_cmd_addr : lsu_cmd_addr;
    end
    ram_din         = (fire & grant_lsu) ? lsu_cmd_wdata : '0;

    // First response cycle passes SRAM data straight through; later cycles replay the hold copy.
    rsp_data        = first_q ? (wr_q ? '0 : ram_dout) : hold_q;
    ifu_rsp_valid   = in_rsp & ~owner_lsu_q;
    lsu_rsp_valid   = in_rsp & owner_lsu_q;
    ifu_rsp_rdata   = ifu_rsp_valid ? rsp_data : '0;
    lsu_rsp_rdata   = lsu_rsp_valid ? rsp_data : '0;
  end

  always_comb begin
    state_d     = state_q;
    owner_lsu_d = owner_lsu_q;
    wr_d        = wr_q;
    first_d     = fire;
    hold_d      = first_q ? rsp_data : hold_q;
    starve_d    = starve_q;
    idle_d      = idle_q;

    if (fire) begin
      owner_lsu_d = grant_lsu;
      wr_d        = grant_lsu & ~lsu_cmd_read;
    end

    if (fire & grant_ifu) begin
      starve_d = '0;
    end else if (fire & grant_lsu & ifu_cmd_valid & ~starved) begin
      starve_d = starve_q + 1'b1;
    end

    if (any_valid | ~cfg_ls_en) begin
      idle_d = '0;
    end else if ((state_q == StIdle) && (idle_q != IW'(LS_IDLE))) begin
      idle_d = idle_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (fire) begin
          state_d = StRsp;
        end else if (idle_d == IW'(LS_IDLE)) begin
          state_d = StSleep;
        end
      end
      StRsp: begin
        if (owner_rsp_ready) begin
          state_d = fire ? StRsp : StIdle;
        end
      end
      StSleep: begin
        // Wake costs one cycle: no grant while ram_ls is still high.
        if (any_valid | ~cfg_ls_en) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_lsu_q <= 1'b0;
      wr_q        <= 1'b0;
      first_q     <= 1'b0;
      hold_q      <= '0;
      starve_q    <= '0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      wr_q        <= wr_d;
      first_q     <= first_d;
      hold_q      <= hold_d;
      starve_q    <= starve_d;
      idle_q      <= idle_d;
    end
  end

endmodule

// File: tb/tb_e203_itcm_arbt_ctrl.sv
module tb_e203_itcm_arbt_ctrl;

  localparam int AW = 13;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int STARVE_MAX = 4;
  localparam int LS_IDLE = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_ls_en = 1'b0;
  logic          ifu_cmd_valid = 1'b0;
  logic          ifu_cmd_ready;
  logic [AW-1:0] ifu_cmd_addr = '0;
  logic          ifu_rsp_valid;
  logic          ifu_rsp_ready = 1'b1;
  logic [DW-1:0] ifu_rsp_rdata;
  logic          lsu_cmd_valid = 1'b0;
  logic          lsu_cmd_ready;
  logic          lsu_cmd_read = 1'b1;
  logic [AW-1:0] lsu_cmd_addr = '0;
  logic [DW-1:0] lsu_cmd_wdata = '0;
  logic [MW-1:0] lsu_cmd_wmask = '0;
  logic          lsu_rsp_valid;
  logic          lsu_rsp_ready = 1'b1;
  logic [DW-1:0] lsu_rsp_rdata;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ram_ls;

  int checks = 0;
  int failures = 0;

  // SRAM behavioural model driven by the DUT pins, plus an independent expected-content copy.
  logic [DW-1:0] mem     [1 << AW];
  logic [DW-1:0] ref_mem [1 << AW];
  logic [DW-1:0] sram_q;
  logic          ovr_en = 1'b0;
  logic [DW-1:0] ovr_val = '0;

  assign ram_dout = ovr_en ? ovr_val : sram_q;

  always #5 clk = ~clk;

  e203_itcm_arbt_ctrl #(
    .AW(AW), .DW(DW), .MW(MW), .STARVE_MAX(STARVE_MAX), .LS_IDLE(LS_IDLE)
  ) dut (
    .clk(clk), .rst(rst), .cfg_ls_en(cfg_ls_en),
    .ifu_cmd_valid(ifu_cmd_valid), .ifu_cmd_ready(ifu_cmd_ready), .ifu_cmd_addr(ifu_cmd_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
    .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready), .lsu_cmd_read(lsu_cmd_read),
    .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_ls(ram_ls)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] w,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    for (int b = 0; b < MW; b++) r[b*8 +: 8] = m[b] ? w[b*8 +: 8] : o[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_cs) begin
      sram_q <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= merge(mem[ram_addr], ram_din, ram_wem);
    end
  end

  // The SRAM must never be selected while in light sleep.
  always @(negedge clk) begin
    #3;
    if (ram_ls) begin
      checks++;
      if (ram_cs !== 1'b0) begin
        failures++;
        $display("FAIL cs_in_sleep: ram_cs=%b while ram_ls=1, want 0", ram_cs);
      end
    end
  end

  task automatic test_reset;
    ifu_cmd_valid = 1'b1;
    lsu_cmd_valid = 1'b1;
    #1;
    checks++;
    if ({ifu_cmd_ready, lsu_cmd_ready, ifu_rsp_valid, lsu_rsp_valid, ram_cs, ram_we, ram_ls}
        !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b%b%b%b%b%b%b want 0000000", ifu_cmd_ready, lsu_cmd_ready,
               ifu_rsp_valid, lsu_rsp_valid, ram_cs, ram_we, ram_ls);
    end
    checks++;
    if ({ram_addr, ram_wem, ram_din, ifu_rsp_rdata, lsu_rsp_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data: addr=%h wem=%h din=%h want all 0", ram_addr, ram_wem, ram_din);
    end
    @(negedge clk);
    ifu_cmd_valid = 1'b0;
    lsu_cmd_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_ifu_read;
    @(negedge clk);
    ifu_cmd_valid = 1'b1;
    ifu_cmd_addr  = 13'h0010;
    ifu_rsp_ready = 1'b1;
    #1;
    checks++;
    if ({ram_cs, ram_we, ifu_cmd_ready, ram_addr} !== {3'b101, 13'h0010}) begin
      failures++;
      $display("FAIL ifu_access: cs=%b we=%b rdy=%b addr=%h want 1 0 1 0010",
               ram_cs, ram_we, ifu_cmd_ready, ram_addr);
    end
    @(negedge clk);
    ifu_cmd_valid = 1'b0;
    #1;
    checks++;
    if (ifu_rsp_valid !== 1'b1 || lsu_rsp_valid !== 1'b0 ||
        ifu_rsp_rdata !== 64'h1122334455667788) begin
      failures++;
      $display("FAIL ifu_rsp: valid=%b rdata=%h want 1 1122334455667788",
               ifu_rsp_valid, ifu_rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_starve;
    int cnt = 0;
    bit exp_ifu;
    bit prev_act = 0;
    bit prev_ifu = 0;
    logic [AW-1:0] prev_addr = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ifu_rsp_ready = 1'b1;
      lsu_rsp_ready = 1'b1;
      if (i < 6) begin
        ifu_cmd_valid = 1'b1;
        lsu_cmd_valid = 1'b1;
        lsu_cmd_read  = 1'b1;
        ifu_cmd_addr  = AW'($urandom_range(256, 511));
        lsu_cmd_addr  = AW'($urandom_range(512, 767));
      end else begin
        ifu_cmd_valid = 1'b0;
        lsu_cmd_valid = 1'b0;
      end
      #1;
      if (prev_act) begin
        checks++;
        if ((prev_ifu ? ifu_rsp_rdata : lsu_rsp_rdata) !== ref_mem[prev_addr] ||
            ifu_rsp_valid !== prev_ifu || lsu_rsp_valid !== !prev_ifu) begin
          failures++;
          $display("FAIL starve_rsp[%0d]: ifu_v=%b lsu_v=%b data=%h want ifu_v=%b data=%h", i,
                   ifu_rsp_valid, lsu_rsp_valid, prev_ifu ? ifu_rsp_rdata : lsu_rsp_rdata,
                   prev_ifu, ref_mem[prev_addr]);
        end
      end
      prev_act = 0;
      if (i < 6) begin
        exp_ifu = (cnt == STARVE_MAX);
        cnt = exp_ifu ? 0 : cnt + 1;
        checks++;
        if (ifu_cmd_ready !== exp_ifu || lsu_cmd_ready !== !exp_ifu) begin
          failures++;
          $display("FAIL starve_grant[%0d]: ifu_rdy=%b lsu_rdy=%b want ifu_rdy=%b", i,
                   ifu_cmd_ready, lsu_cmd_ready, exp_ifu);
        end
        prev_act  = 1;
        prev_ifu  = exp_ifu;
        prev_addr = exp_ifu ? ifu_cmd_addr : lsu_cmd_addr;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_write;
    logic [DW-1:0] expv;
    expv = {ref_mem[13'h1FFF][63:32], 32'hCCCC_DDDD};
    @(negedge clk);
    lsu_cmd_valid = 1'b1;
    lsu_cmd_read  = 1'b0;
    lsu_cmd_addr  = 13'h1FFF;
    lsu_cmd_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    lsu_cmd_wmask = 8'h0F;
    #1;
    checks++;
    if ({ram_cs, ram_we, lsu_cmd_ready, ram_wem, ram_addr} !== {3'b111, 8'h0F, 13'h1FFF} ||
        ram_din !== 64'hAAAA_BBBB_CCCC_DDDD) begin
      failures++;
      $display("FAIL wr_access: cs=%b we=%b rdy=%b wem=%h addr=%h want 1 1 1 0f 1fff",
               ram_cs, ram_we, lsu_cmd_ready, ram_wem, ram_addr);
    end
    ref_mem[13'h1FFF] = merge(ref_mem[13'h1FFF], 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
    @(negedge clk);
    lsu_cmd_valid = 1'b0;
    lsu_cmd_read  = 1'b1;
    #1;
    checks++;
    if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== '0) begin
      failures++;
      $display("FAIL wr_rsp: valid=%b rdata=%h want 1 0", lsu_rsp_valid, lsu_rsp_rdata);
    end
    @(negedge clk);
    lsu_cmd_valid = 1'b1;
    #1;
    @(negedge clk);
    lsu_cmd_valid = 1'b0;
    #1;
    checks++;
    if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== expv) begin
      failures++;
      $display("FAIL wr_readback: valid=%b rdata=%h want 1 %h", lsu_rsp_valid, lsu_rsp_rdata,
               expv);
    end
    @(negedge clk);
  endtask

  task automatic test_hold;
    @(negedge clk);
    ifu_cmd_valid = 1'b1;
    ifu_cmd_addr  = 13'h0123;
    ifu_rsp_ready = 1'b0;
    #1;
    @(negedge clk);
    ifu_cmd_addr = 13'h0124;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        ovr_en  = 1'b1;
        ovr_val = {$urandom, $urandom};
      end
      if (k == 3) ifu_rsp_ready = 1'b1;
      #1;
      checks++;
      if (ifu_rsp_valid !== 1'b1 || ifu_rsp_rdata !== ref_mem[13'h0123] ||
          ifu_cmd_ready !== (k == 3)) begin
        failures++;
        $display("FAIL hold[%0d]: valid=%b rdata=%h rdy=%b want 1 %h %b", k, ifu_rsp_valid,
                 ifu_rsp_rdata, ifu_cmd_ready, ref_mem[13'h0123], k == 3);
      end
    end
    @(negedge clk);
    ovr_en = 1'b0;
    ifu_cmd_valid = 1'b0;
    #1;
    checks++;
    if (ifu_rsp_valid !== 1'b1 || ifu_rsp_rdata !== ref_mem[13'h0124]) begin
      failures++;
      $display("FAIL hold_next: valid=%b rdata=%h want 1 %h", ifu_rsp_valid, ifu_rsp_rdata,
               ref_mem[13'h0124]);
    end
    @(negedge clk);
  endtask

  task automatic test_sleep;
    int n = 0;
    repeat (2) @(negedge clk);
    cfg_ls_en = 1'b1;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (ram_ls) break;
    end
    checks++;
    if (n !== LS_IDLE) begin
      failures++;
      $display("FAIL sleep_entry: ram_ls after %0d cycles, want %0d", n, LS_IDLE);
    end
    repeat (3) @(negedge clk);
    ifu_cmd_valid = 1'b1;
    ifu_cmd_addr  = 13'h0042;
    #1;
    checks++;
    if ({ram_ls, ram_cs, ifu_cmd_ready} !== 3'b100) begin
      failures++;
      $display("FAIL wake_cycle: ls=%b cs=%b rdy=%b want 1 0 0", ram_ls, ram_cs, ifu_cmd_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({ram_ls, ram_cs, ifu_cmd_ready} !== 3'b011) begin
      failures++;
      $display("FAIL wake_grant: ls=%b cs=%b rdy=%b want 0 1 1", ram_ls, ram_cs, ifu_cmd_ready);
    end
    @(negedge clk);
    ifu_cmd_valid = 1'b0;
    cfg_ls_en = 1'b0;
    #1;
    checks++;
    if (ifu_rsp_valid !== 1'b1 || ifu_rsp_rdata !== ref_mem[13'h0042]) begin
      failures++;
      $display("FAIL wake_rsp: valid=%b rdata=%h want 1 %h", ifu_rsp_valid, ifu_rsp_rdata,
               ref_mem[13'h0042]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    ifu_cmd_valid = 1'b1;
    ifu_cmd_addr  = 13'h0077;
    ifu_rsp_ready = 1'b0;
    #1;
    @(negedge clk);
    #1;
    checks++;
    if (ifu_rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre: ifu_rsp_valid=%b want 1", ifu_rsp_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ifu_rsp_valid, lsu_rsp_valid, ifu_cmd_ready, lsu_cmd_ready, ram_cs} !== 5'b0) begin
      failures++;
      $display("FAIL rstmid_drop: rspv=%b%b rdy=%b%b cs=%b want all 0", ifu_rsp_valid,
               lsu_rsp_valid, ifu_cmd_ready, lsu_cmd_ready, ram_cs);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ifu_rsp_valid !== 1'b0 || ifu_cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_idle: rspv=%b rdy=%b want 0 1", ifu_rsp_valid, ifu_cmd_ready);
    end
    @(negedge clk);
    ifu_cmd_valid = 1'b0;
    ifu_rsp_ready = 1'b1;
    #1;
    checks++;
    if (ifu_rsp_valid !== 1'b1 || ifu_rsp_rdata !== ref_mem[13'h0077]) begin
      failures++;
      $display("FAIL rstmid_rsp: valid=%b rdata=%h want 1 %h", ifu_rsp_valid, ifu_rsp_rdata,
               ref_mem[13'h0077]);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    bit            exp_lsu_q[$];
    logic [DW-1:0] exp_data_q[$];
    bit            ifu_acc = 1;
    bit            lsu_acc = 1;
    bit            dense;
    for (int cyc = 0; cyc < 620; cyc++) begin
      @(negedge clk);
      dense = ((cyc / 100) % 2) == 0;
      cfg_ls_en = (cyc >= 200);
      if (cyc >= 600) begin
        ifu_cmd_valid = 1'b0;
        lsu_cmd_valid = 1'b0;
      end else begin
        if (!ifu_cmd_valid || ifu_acc) begin
          ifu_cmd_valid = dense ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 99) < 3);
          ifu_cmd_addr  = AW'($urandom_range(0, 63));
        end
        if (!lsu_cmd_valid || lsu_acc) begin
          lsu_cmd_valid = dense ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 99) < 3);
          lsu_cmd_read  = $urandom_range(0, 1);
          lsu_cmd_addr  = AW'($urandom_range(0, 63));
          lsu_cmd_wdata = {$urandom, $urandom};
          lsu_cmd_wmask = MW'($urandom);
        end
      end
      ifu_rsp_ready = (cyc >= 600) || ($urandom_range(0, 3) != 0);
      lsu_rsp_ready = (cyc >= 600) || ($urandom_range(0, 3) != 0);
      #1;
      ifu_acc = 0;
      lsu_acc = 0;
      if (ifu_rsp_valid && ifu_rsp_ready) begin
        checks++;
        if (exp_lsu_q.size() == 0 || exp_lsu_q[0] || exp_data_q[0] !== ifu_rsp_rdata) begin
          failures++;
          $display("FAIL rnd_ifu_rsp[%0d]: rdata=%h pending=%0d", cyc, ifu_rsp_rdata,
                   exp_lsu_q.size());
        end
        if (exp_lsu_q.size() != 0) begin
          void'(exp_lsu_q.pop_front());
          void'(exp_data_q.pop_front());
        end
      end
      if (lsu_rsp_valid && lsu_rsp_ready) begin
        checks++;
        if (exp_lsu_q.size() == 0 || !exp_lsu_q[0] || exp_data_q[0] !== lsu_rsp_rdata) begin
          failures++;
          $display("FAIL rnd_lsu_rsp[%0d]: rdata=%h pending=%0d", cyc, lsu_rsp_rdata,
                   exp_lsu_q.size());
        end
        if (exp_lsu_q.size() != 0) begin
          void'(exp_lsu_q.pop_front());
          void'(exp_data_q.pop_front());
        end
      end
      if (ifu_cmd_ready && lsu_cmd_ready) begin
        failures++;
        $display("FAIL rnd_dual_grant[%0d]: both ready high, want at most one", cyc);
      end
      if (ifu_cmd_valid && ifu_cmd_ready) begin
        ifu_acc = 1;
        exp_lsu_q.push_back(1'b0);
        exp_data_q.push_back(ref_mem[ifu_cmd_addr]);
      end
      if (lsu_cmd_valid && lsu_cmd_ready) begin
        lsu_acc = 1;
        exp_lsu_q.push_back(1'b1);
        if (lsu_cmd_read) begin
          exp_data_q.push_back(ref_mem[lsu_cmd_addr]);
        end else begin
          exp_data_q.push_back('0);
          ref_mem[lsu_cmd_addr] = merge(ref_mem[lsu_cmd_addr], lsu_cmd_wdata, lsu_cmd_wmask);
        end
      end
    end
    checks++;
    if (exp_lsu_q.size() != 0) begin
      failures++;
      $display("FAIL rnd_drain: %0d responses never returned, want 0", exp_lsu_q.size());
    end
    cfg_ls_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = {$urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    mem[13'h0010]     = 64'h1122334455667788;
    ref_mem[13'h0010] = 64'h1122334455667788;
    test_reset();
    test_ifu_read();
    test_starve();
    test_write();
    test_hold();
    test_sleep();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e203_itcm_arbt_ctrl.md
Name: e203_itcm_arbt_ctrl

Overview:
- Arbitrates two requesters, IFU instruction fetch and LSU load/store, onto the single-port ITCM SRAM.
- Drives the SRAM cs/we/addr/wem/din pins and returns read data through valid/ready response channels.
- Applies LSU-first priority with an anti-starvation counter for IFU.
- Places the SRAM in light sleep after a programmable idle period.

Parameters:
- AW, 13, SRAM word-address width.
- DW, 64, data width.
- MW, 8, write-mask width (DW/8).
- STARVE_MAX, 4, consecutive IFU arbitration losses before IFU is forced to win.
- LS_IDLE, 16, idle cycles before ram_ls asserts; counter width is clog2(LS_IDLE+1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_ls_en  in  1  enables automatic light sleep
- ifu_cmd_valid  in  1  IFU request
- ifu_cmd_ready  out  1  IFU request accepted
- ifu_cmd_addr  in  AW  IFU word address
- ifu_rsp_valid  out  1  IFU read data valid
- ifu_rsp_ready  in  1  IFU consumes response
- ifu_rsp_rdata  out  DW  IFU read data
- lsu_cmd_valid  in  1  LSU request
- lsu_cmd_ready  out  1  LSU request accepted
- lsu_cmd_read  in  1  1=read, 0=write
- lsu_cmd_addr  in  AW  LSU word address
- lsu_cmd_wdata  in  DW  write data
- lsu_cmd_wmask  in  MW  byte enables
- lsu_rsp_valid  out  1  LSU response valid (reads and writes)
- lsu_rsp_ready  in  1  LSU consumes response
- lsu_rsp_rdata  out  DW  LSU read data; 0 for writes
- ram_cs  out  1  SRAM chip select
- ram_we  out  1  SRAM write enable
- ram_addr  out  AW  SRAM address
- ram_wem  out  MW  SRAM byte write mask
- ram_din  out  DW  SRAM write data
- ram_dout  in  DW  SRAM read data, valid the cycle after cs
- ram_ls  out  1  SRAM light sleep

Behaviour:
- Reset values:
  - All cmd_ready, rsp_valid, ram_cs, ram_we and ram_ls are 0.
  - All data outputs and internal state (hold register, owner, starve counter, idle counter) are 0.
  - Reset asserted mid-transaction drops any pending response with no completion.
- Single-transaction pipeline with states IDLE, RSP and SLEEP.
- Accept condition: accept = !ram_ls & (state==IDLE | (state==RSP & owner_rsp_valid & owner_rsp_ready)). cmd_ready is driven only to the grant winner and only when accept=1.
- Access cycle t: ram_cs=1; ram_we=1 only for an LSU write. For a write, ram_wem=wmask; otherwise ram_wem=0. ram_addr and ram_din come from the winner. The owner is recorded and state moves to RSP.
- Cycle t+1:
  - The owner's rsp_valid=1.
  - rsp_rdata is muxed from ram_dout combinationally in the first response cycle and loaded into a hold register on that same edge. Later cycles drive rsp_rdata from the hold register, so data stays stable while rsp_ready is low.
  - Read latency is 1 cycle; back-to-back accepts give 1 transaction per cycle.
- Leaving RSP: rsp handshake with no new accept → IDLE. Handshake with a new accept → stay in RSP with the new owner.
- Arbitration:
  - LSU wins when both requesters are valid, unless starve_cnt==STARVE_MAX, in which case IFU wins.
  - starve_cnt increments when IFU is valid, the LSU wins and accept=1. It clears to 0 on any IFU grant. It saturates at STARVE_MAX.
- Light sleep:
  - idle_cnt increments on each cycle with state==IDLE, no cmd_valid and cfg_ls_en=1. It saturates at LS_IDLE and clears on any cmd_valid or when cfg_ls_en=0.
  - When idle_cnt==LS_IDLE, ram_ls=1 and state becomes SLEEP.
  - In SLEEP, any cmd_valid (or cfg_ls_en=0) clears ram_ls on the next edge with no grant that cycle. The wake penalty is 1 cycle and the first grant follows in the next cycle.
- ram_cs is never asserted while ram_ls=1.

Test Plan:
- Single IFU read of addr 0x0010, preloaded with 0x1122334455667788: cs at t with we=0 → ifu_rsp_valid at t+1 with rdata 0x1122334455667788.
- Simultaneous IFU and LSU valid held for 6 cycles with responses always ready: grant order is LSU×4, IFU, LSU; starve_cnt returns to 0 after the IFU grant.
- LSU write to addr 0x1FFF, wdata 0xAAAA_BBBB_CCCC_DDDD, wmask 0x0F: ram_we=1 and ram_wem=0x0F at t; lsu_rsp_valid at t+1 with rdata 0. A following read returns only the low 4 bytes updated.
- IFU read with ifu_rsp_ready held low for 3 cycles while ram_dout changes: rdata holds the t+1 value, cmd_ready stays 0, and accept happens in the cycle ready rises.
- cfg_ls_en=1 with no requests: ram_ls rises after 16 idle cycles. IFU request then gives 1 cycle with ram_ls clearing and no cs, then cs on the next cycle.
- Reset asserted during RSP with rsp_ready=0: all valids and ready drop immediately (asynchronously), and the state is IDLE after reset release.
